// File: rtl/digit_sequencer.sv
// Two-requester round-robin binary-to-radix converter: one digit per cycle via repeated divide.
// Latency: gnt to done is DIGITS+2 cycles; back-to-back period DIGITS+3 cycles.
// Backpressure: req is a held level, honoured only in IDLE; results hold until the next conversion.
module digit_sequencer #(
  parameter int W_IN   = 10,
  parameter int DIGITS = 4,
  parameter int BASE   = 10
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [1:0]            req,
  input  logic [W_IN-1:0]       val0,
  input  logic [W_IN-1:0]       val1,
  output logic [1:0]            gnt,
  output logic                  busy,
  output logic                  done,
  output logic                  done_id,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  ovf
);

  localparam int              CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0]   K_LAST = CW'(DIGITS - 1);
  localparam logic [W_IN-1:0] RADIX  = W_IN'(BASE);

  typedef enum logic [1:0] {IDLE, LOAD, DIVIDE, DONE} state_t;

  state_t              state, state_nxt;
  logic [W_IN-1:0]     work;
  logic [4*DIGITS-1:0] staging;
  logic [CW-1:0]       k;
  logic                rr_pref;
  logic                owner;
  logic                win_vld;
  logic                win_id;
  logic [W_IN-1:0]     quot;
  logic [3:0]          rem_nib;

  assign quot    = work / RADIX;
  assign rem_nib = 4'(work % RADIX);
  assign busy    = (state == LOAD) || (state == DIVIDE);

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    win_vld = |req;
    win_id  = 1'b0;
    case (req)
      2'b10:   win_id = 1'b1;
      2'b11:   win_id = rr_pref;
      default: win_id = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = LOAD;
      LOAD:    state_nxt = DIVIDE;
      DIVIDE:  if (k == K_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      gnt     <= '0;
      done    <= 1'b0;
      done_id <= 1'b0;
      digits  <= '0;
      ovf     <= 1'b0;
      work    <= '0;
      staging <= '0;
      k       <= '0;
      rr_pref <= 1'b0;
      owner   <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            gnt     <= win_id ? 2'b10 : 2'b01;
            owner   <= win_id;
            rr_pref <= ~win_id;
            work    <= win_id ? val1 : val0;
          end
        end
        LOAD: begin
          k       <= '0;
          staging <= '0;
        end
        DIVIDE: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (k == CW'(i)) staging[i*4 +: 4] <= rem_nib;
          end
          work <= quot;
          k    <= k + CW'(1);
        end
        DONE: begin
          // Any residue left in work means the operand needed more digits.
          digits  <= staging;
          ovf     <= |work;
          done_id <= owner;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_sequencer.sv
// Directed bench for digit_sequencer: three instances cover decimal/4, decimal/3 and hex/4 configurations.
module tb_digit_sequencer;

  logic clk;
  logic nrst;

  logic [1:0]  reqa, gnta;
  logic [13:0] a0, a1;
  logic        busya, donea, ida, ovfa;
  logic [15:0] diga;

  logic [1:0]  reqb, gntb;
  logic [9:0]  b0, b1;
  logic        busyb, doneb, idb, ovfb;
  logic [11:0] digb;

  logic [1:0]  reqc, gntc;
  logic [9:0]  c0, c1;
  logic        busyc, donec, idc, ovfc;
  logic [15:0] digc;

  int n_vec;
  int n_err;
  int n;
  int extra;

  digit_sequencer #(.W_IN(14), .DIGITS(4), .BASE(10)) u_a (
    .clk(clk), .nrst(nrst), .req(reqa), .val0(a0), .val1(a1), .gnt(gnta),
    .busy(busya), .done(donea), .done_id(ida), .digits(diga), .ovf(ovfa));

  digit_sequencer #(.W_IN(10), .DIGITS(3), .BASE(10)) u_b (
    .clk(clk), .nrst(nrst), .req(reqb), .val0(b0), .val1(b1), .gnt(gntb),
    .busy(busyb), .done(doneb), .done_id(idb), .digits(digb), .ovf(ovfb));

  digit_sequencer #(.W_IN(10), .DIGITS(4), .BASE(16)) u_c (
    .clk(clk), .nrst(nrst), .req(reqc), .val0(c0), .val1(c1), .gnt(gntc),
    .busy(busyc), .done(donec), .done_id(idc), .digits(digc), .ovf(ovfc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_gnt_a(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (gnta == 2'b00 && cnt < 20);
  endtask

  task automatic wait_done_a(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!donea && cnt < 20);
  endtask

  task automatic conv_a(input string tag, input logic [1:0] r, input logic [13:0] v0,
                        input logic [13:0] v1, input logic [1:0] eg, input logic [15:0] ed,
                        input logic eo, input logic ei);
    int c;
    @(negedge clk);
    reqa = r;
    a0   = v0;
    a1   = v1;
    wait_gnt_a(c);
    chk({tag, "_gnt"}, 32'(gnta), 32'(eg));
    reqa = 2'b00;
    a0   = '1;
    a1   = '1;
    wait_done_a(c);
    chk({tag, "_lat"}, 32'(c), 32'd6);
    chk({tag, "_dig"}, 32'(diga), 32'(ed));
    chk({tag, "_ovf"}, 32'(ovfa), 32'(eo));
    chk({tag, "_id"},  32'(ida), 32'(ei));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    nrst = 1'b0;
    reqa = '0; a0 = '0; a1 = '0;
    reqb = '0; b0 = '0; b1 = '0;
    reqc = '0; c0 = '0; c1 = '0;

    repeat (2) @(negedge clk);
    chk("rst_gnt",  32'(gnta),  32'd0);
    chk("rst_busy", 32'(busya), 32'd0);
    chk("rst_done", 32'(donea), 32'd0);
    chk("rst_dig",  32'(diga),  32'd0);
    chk("rst_ovf",  32'(ovfa),  32'd0);
    chk("rst_id",   32'(ida),   32'd0);
    nrst = 1'b1;

    // Both requesters held: order 0,1,0 with back-to-back period DIGITS+3.
    @(negedge clk);
    reqa = 2'b11;
    a0 = 14'd321;
    a1 = 14'd4567;
    wait_gnt_a(n);
    chk("rr1_gnt",  32'(gnta),  32'h1);
    chk("rr1_busy", 32'(busya), 32'd1);
    wait_done_a(n);
    chk("rr1_lat", 32'(n), 32'd6);
    chk("rr1_id",  32'(ida), 32'd0);
    chk("rr1_dig", 32'(diga), 32'h0321);
    wait_gnt_a(n);
    chk("rr2_gap", 32'(n), 32'd1);
    chk("rr2_gnt", 32'(gnta), 32'h2);
    wait_done_a(n);
    chk("rr2_id",  32'(ida), 32'd1);
    chk("rr2_dig", 32'(diga), 32'h4567);
    wait_gnt_a(n);
    chk("rr3_gap", 32'(n), 32'd1);
    chk("rr3_gnt", 32'(gnta), 32'h1);
    reqa = 2'b00;
    wait_done_a(n);
    chk("rr3_id",  32'(ida), 32'd0);
    chk("rr3_dig", 32'(diga), 32'h0321);

    // Pointer now prefers requester 1, but a lone req 0 still wins.
    conv_a("d1234", 2'b01, 14'd1234, 14'd0, 2'b01, 16'h1234, 1'b0, 1'b0);
    @(negedge clk);
    chk("hold_done", 32'(donea), 32'd0);
    chk("hold_dig",  32'(diga),  32'h1234);
    conv_a("d0",     2'b01, 14'd0,     14'd0,     2'b01, 16'h0000, 1'b0, 1'b0);
    conv_a("d9999",  2'b01, 14'd9999,  14'd0,     2'b01, 16'h9999, 1'b0, 1'b0);
    conv_a("d10000", 2'b01, 14'd10000, 14'd0,     2'b01, 16'h0000, 1'b1, 1'b0);
    conv_a("d16383", 2'b10, 14'd5,     14'd16383, 2'b10, 16'h6383, 1'b1, 1'b1);

    // A request withdrawn between clock edges must not start anything.
    @(negedge clk);
    reqa = 2'b01;
    #2 reqa = 2'b00;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (gnta != 2'b00 || busya) extra++;
    end
    chk("drop_idle", 32'(extra), 32'd0);

    // Three-digit decimal: 1023 overflows, leaving 023.
    @(negedge clk);
    reqb = 2'b10;
    b0 = 10'd5;
    b1 = 10'd1023;
    n = 0;
    do begin @(negedge clk); n++; end while (gntb == 2'b00 && n < 20);
    chk("b_gnt", 32'(gntb), 32'h2);
    reqb = 2'b00;
    n = 0;
    do begin @(negedge clk); n++; end while (!doneb && n < 20);
    chk("b_lat", 32'(n), 32'd5);
    chk("b_dig", 32'(digb), 32'h023);
    chk("b_ovf", 32'(ovfb), 32'd1);
    chk("b_id",  32'(idb),  32'd1);

    // Hex: requests churn while busy and must not produce another grant.
    @(negedge clk);
    reqc = 2'b01;
    c0 = 10'h2AF;
    c1 = 10'h3FF;
    n = 0;
    do begin @(negedge clk); n++; end while (gntc == 2'b00 && n < 20);
    chk("c_gnt", 32'(gntc), 32'h1);
    n = 0;
    extra = 0;
    do begin
      @(negedge clk);
      n++;
      if (gntc != 2'b00) extra++;
      if (donec) reqc = 2'b00;
      else       reqc = reqc + 2'd1;
    end while (!donec && n < 20);
    chk("c_lat",   32'(n),     32'd6);
    chk("c_extra", 32'(extra), 32'd0);
    chk("c_dig",   32'(digc),  32'h02AF);
    chk("c_ovf",   32'(ovfc),  32'd0);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (gntc != 2'b00) extra++;
    end
    chk("c_post", 32'(extra), 32'd0);

    // Reset during DIVIDE aborts the conversion and restores requester-0 priority.
    @(negedge clk);
    reqa = 2'b01;
    a0 = 14'd1234;
    wait_gnt_a(n);
    chk("ab_gnt", 32'(gnta), 32'h1);
    reqa = 2'b00;
    repeat (2) @(negedge clk);
    chk("ab_busy_pre", 32'(busya), 32'd1);
    #2 nrst = 1'b0;
    #1;
    chk("ab_busy", 32'(busya), 32'd0);
    chk("ab_dig",  32'(diga),  32'd0);
    chk("ab_id",   32'(ida),   32'd0);
    @(negedge clk);
    nrst = 1'b1;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (donea) extra++;
    end
    chk("ab_nodone", 32'(extra), 32'd0);
    reqa = 2'b11;
    a1 = 14'd42;
    wait_gnt_a(n);
    chk("ab_rr_gnt", 32'(gnta), 32'h1);
    reqa = 2'b00;
    wait_done_a(n);
    chk("ab_rr_lat", 32'(n), 32'd6);
    chk("ab_rr_id",  32'(ida), 32'd0);
    chk("ab_rr_dig", 32'(diga), 32'h1234);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/digit_sequencer.md
DIGIT_SEQUENCER -- requirements
Module: digit_sequencer

Interface
REQ-001 SHALL have parameter W_IN, default 10, meaning the width of each binary input value.
REQ-002 SHALL have parameter DIGITS, default 4, meaning the number of output digits produced per conversion.
REQ-003 SHALL have parameter BASE, default 10, meaning the radix, legal range 2..16.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port nrst  input  1  meaning the reset, asynchronous and active-low.
REQ-006 SHALL have port req  input  2  meaning per-requester conversion request, level, held until granted.
REQ-007 SHALL have port val0  input  W_IN  meaning requester 0 operand, sampled only in its grant cycle.
REQ-008 SHALL have port val1  input  W_IN  meaning requester 1 operand, sampled only in its grant cycle.
REQ-009 SHALL have port gnt  output  2  meaning one-hot, one-cycle acceptance pulse.
REQ-010 SHALL have port busy  output  1  meaning a conversion is in progress (states LOAD..DIVIDE).
REQ-011 SHALL have port done  output  1  meaning one-cycle result-valid pulse.
REQ-012 SHALL have port done_id  output  1  meaning the requester index that owns the current result.
REQ-013 SHALL have port digits  output  4*DIGITS  meaning the result, nibble k = k-th least significant digit.
REQ-014 SHALL have port ovf  output  1  meaning the operand did not fit in DIGITS digits.

Function
REQ-015 SHALL implement states IDLE, LOAD, DIVIDE and DONE.
REQ-016 In IDLE with any req bit set, SHALL pulse the gnt bit of the arbitration winner, latch that requester's value into a W_IN-bit work register, and go to LOAD.
REQ-017 Arbitration SHALL be round-robin: with both req set, the winner is the requester not served last; after reset, requester 0 wins.
REQ-018 With a single req bit set, that requester SHALL win regardless of the round-robin pointer.
REQ-019 LOAD SHALL clear the digit counter and the staging digit register, then go to DIVIDE.
REQ-020 Each DIVIDE cycle SHALL write work mod BASE into staging nibble k, replace work with work / BASE, and increment k.
REQ-021 DIVIDE SHALL last exactly DIGITS cycles, then go to DONE.
REQ-022 DONE SHALL copy staging to digits, set ovf to (work != 0), set done_id, pulse done for one cycle, and return to IDLE.
REQ-023 Latency SHALL be DIGITS+2 cycles from the gnt pulse to the done pulse.
REQ-024 The next grant SHALL occur no earlier than the cycle after done; back-to-back period = DIGITS+3 cycles.
REQ-025 req SHALL be ignored outside IDLE.
REQ-026 A req bit dropped before its grant SHALL cause no conversion and no state change.
REQ-027 digits, ovf and done_id SHALL hold their values from done until the next DONE state.
REQ-028 Division remainders SHALL be truncated to 4 bits and quotients to W_IN bits, with no width-extension warnings.
REQ-029 Operand 0 SHALL produce all-zero digits with ovf=0.
REQ-030 Leading digit positions beyond the operand's magnitude SHALL be 0 (no blanking).

Reset
REQ-031 On nrst low, state SHALL become IDLE immediately, regardless of clk.
REQ-032 Reset SHALL clear gnt, busy, done, done_id, ovf, digits, the work, staging and counter registers, and the round-robin pointer (requester 0 preferred).
REQ-033 Reset asserted mid-conversion SHALL abort it with no done pulse; after release, the first conversion SHALL behave as after power-up.

Verification
REQ-034 Bench SHALL cover: req=01, val0=1234 -> gnt=01, then done 6 cycles later, digits=0x1234, ovf=0, done_id=0.
REQ-035 Bench SHALL cover: req=10, val1=1023, DIGITS=3 -> digits=0x023, ovf=1, done_id=1.
REQ-036 Bench SHALL cover: req=11 held for three conversions -> grant order 0,1,0, each done_id matching its grant.
REQ-037 Bench SHALL cover: val0=0 -> digits=0x0000, ovf=0; val0=9999 -> digits=0x9999, ovf=0.
REQ-038 Bench SHALL cover: nrst pulsed low during DIVIDE -> busy=0 asynchronously, no done pulse, digits=0; a following req=11 grants requester 0.
REQ-039 Bench SHALL cover: BASE=16, val0=0x2AF -> digits=0x02AF; req toggled during busy -> no extra gnt.
